scan_calculator: RTL
====================

Name: scan_calculator

Overview:
- Parametrised, clocked successor to the 4-bit combinational calculator and FND path.
- Captures two WIDTH-bit operands and an operator on a start pulse, then computes add, sub, mul or div; division is sequential.
- Converts the result to BCD with a serial double-dabble and drives a DIGITS-wide multiplexed 7-segment display with internal digit scanning.
- Sits between the switch/button input logic and the FND pins.

Parameters:
- WIDTH, 8, operand width in bits; result width RW = 2*WIDTH.
- DIGITS, 4, number of FND digits; max displayable magnitude MAXV = 10^DIGITS-1.
- SCAN_DIV, 100000, clock cycles each digit is held during scanning (>=2).

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_a  in  WIDTH  operand A, unsigned.
- i_b  in  WIDTH  operand B, unsigned.
- i_selOperator  in  2  operator: 00 add, 01 sub, 10 mul, 11 div.
- i_start  in  1  one-cycle request; sampled only in IDLE.
- i_en  in  1  display enable; 0 turns all digits off.
- o_busy  out  1  high from the cycle after start is accepted until o_done.
- o_done  out  1  one-cycle pulse when the new result is loaded to the display.
- o_error  out  1  sticky until the next accepted start: overflow or divide-by-zero.
- o_digit  out  DIGITS  active-low one-hot digit strobe; bit 0 = least significant digit.
- o_fndFont  out  8  active-low segments {dp,g,f,e,d,c,b,a}.

Behaviour:
- Reset (asynchronous): FSM to IDLE; display value cleared to 0 (non-negative, no error); scan index 0; scan counter 0; o_busy, o_done, o_error = 0; o_digit all 1s; o_fndFont 8'hFF.
- FSM states: IDLE -> CALC -> CONV -> LOAD -> IDLE.
- IDLE: when i_start=1, latch i_a, i_b and i_selOperator; go to CALC. i_start is ignored in every other state.
- CALC, add/sub/mul: one cycle.
  - add: zero-extended sum.
  - sub: if a>=b, result a-b; else magnitude b-a with the negative flag set.
  - mul: full RW-bit product.
- CALC, div: restoring division, one quotient bit per cycle, WIDTH cycles; the quotient is the result and the remainder is discarded. b=0 sets the error flag and still takes WIDTH cycles.
- CONV: double-dabble over RW bits, one bit per cycle, RW cycles.
- Error conditions: error if magnitude > MAXV, or if negative and magnitude > 10^(DIGITS-1)-1.
- LOAD: one cycle. Copy BCD, negative flag and error flag to the display registers. o_done=1 and o_error updates in this cycle.
- Latency from the cycle i_start is sampled to o_done: 2+RW for add/sub/mul; 1+WIDTH+RW for div. With WIDTH=8 that is 18 and 25.
- The display keeps showing the previous result while busy.
- Scanning: the counter counts 0..SCAN_DIV-1. On wrap, the index advances from 0 to DIGITS-1, then back to 0. Scanning runs regardless of FSM state.
- i_en=0 forces o_digit all 1s and o_fndFont 8'hFF. Counters keep running.
- Font, active-low:
  - digits 0-9: C0,F9,A4,B0,99,92,82,F8,80,90.
  - '-': BF.
  - 'E': 86.
  - blank: FF.
- Negative result: digit DIGITS-1 shows '-'; remaining digits show the magnitude.
- Error: digit 0 shows 'E'; all other digits blank.
- Reset mid-operation aborts the computation. No o_done is issued and the display returns to 0.

Optional Feature:
- LEADING_ZERO_BLANK_EN
  - Defined: leading zero digits above the most significant non-zero digit are blank (FF); digit 0 is always shown. A '-' on digit DIGITS-1 is unaffected.
  - Undefined: all digits show zeros, e.g. 0042.

Test Plan:
- Bench configuration: WIDTH=8, DIGITS=4, SCAN_DIV=4, feature undefined unless stated.
- Add: reset, then a=200, b=100, op 00, start -> o_done exactly 18 cycles later; digits show 0,3,0,0 (C0,C0,B0,C0 for digit0..3); o_error=0.
- Sub negative: a=5, b=9, op 01 -> digit3 BF, digit0 99, digits1-2 C0. With LEADING_ZERO_BLANK_EN defined, digits1-2 show FF.
- Mul overflow: a=255, b=255, op 10 -> 65025 > 9999; o_error=1; digit0 86; digits1-3 FF.
- Div: a=200, b=7, op 11 -> o_done 25 cycles later showing 0028. Then b=0 -> o_error=1 and 'E' shown. The next valid start clears o_error.
- Start while busy: pulse i_start again at cycle 5 with different operands -> ignored; exactly one o_done with the first result.
- Reset mid-CONV: assert i_reset_n=0 at cycle 10 -> outputs go to reset values immediately; no o_done.
- Scan and enable:
  - With i_en=1, o_digit steps E,D,B,7 every 4 cycles.
  - With i_en=0, o_digit=F and o_fndFont=FF.

Source files
------------

// File: rtl/scan_calculator.sv
// Clocked add/sub/mul/div calculator with serial double-dabble BCD conversion and a scanned 7-segment driver.
// Optional LEADING_ZERO_BLANK_EN blanks zero digits above the most significant non-zero digit.
module scan_calculator #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 100000
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [WIDTH-1:0]  i_a,
  input  logic [WIDTH-1:0]  i_b,
  input  logic [1:0]        i_selOperator,
  input  logic              i_start,
  input  logic              i_en,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [DIGITS-1:0] o_digit,
  output logic [7:0]        o_fndFont
);
  localparam int RW = 2 * WIDTH;
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(RW + 1);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [63:0] MAXV = 64'(10 ** DIGITS - 1);
  localparam logic [63:0] MAXN = 64'(10 ** (DIGITS - 1) - 1);

  typedef enum logic [1:0] {IDLE, CALC, CONV, LOAD} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, rem_q, rem_d;
  logic [1:0]        op_q, op_d;
  logic [RW-1:0]     res_q, res_d;
  logic              neg_q, neg_d, err_q, err_d, error_q, error_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bcd_q, bcd_d, disp_bcd_q, disp_bcd_d;
  logic              disp_neg_q, disp_neg_d, disp_err_q, disp_err_d;
  logic [SW-1:0]     scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DIGITS-1:0] digit_q, digit_d;
  logic [7:0]        font_q, font_d;
  logic [WIDTH:0]    rem_sh;
  logic              qbit;
  logic [3:0]        sel_nib;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  function automatic logic [BW-1:0] dd_adjust(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++)
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    rem_d      = rem_q;
    res_d      = res_q;
    neg_d      = neg_q;
    err_d      = err_q;
    error_d    = error_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    disp_bcd_d = disp_bcd_q;
    disp_neg_d = disp_neg_q;
    disp_err_d = disp_err_q;
    rem_sh     = {rem_q, a_q[WIDTH-1]};
    qbit       = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          a_d     = i_a;
          b_d     = i_b;
          op_d    = i_selOperator;
          rem_d   = '0;
          res_d   = '0;
          neg_d   = 1'b0;
          err_d   = 1'b0;
          error_d = 1'b0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = CONV;
        case (op_q)
          2'b00: res_d = RW'(a_q) + RW'(b_q);
          2'b01: begin
            if (a_q >= b_q) begin
              res_d = RW'(a_q - b_q);
            end else begin
              res_d = RW'(b_q - a_q);
              neg_d = 1'b1;
            end
          end
          2'b10: res_d = RW'(a_q) * RW'(b_q);
          default: begin
            // Restoring division: dividend bits shift out of a_q into the partial remainder.
            if (rem_sh >= {1'b0, b_q}) begin
              rem_d = WIDTH'(rem_sh - {1'b0, b_q});
              qbit  = 1'b1;
            end else begin
              rem_d = rem_sh[WIDTH-1:0];
            end
            a_d   = a_q << 1;
            res_d = {res_q[RW-2:0], qbit};
            if (b_q == '0) err_d = 1'b1;
            if (cnt_q != CW'(WIDTH - 1)) begin
              cnt_d   = cnt_q + 1'b1;
              state_d = CALC;
            end
          end
        endcase
      end
      CONV: begin
        if (cnt_q == '0 && (64'(res_q) > MAXV || (neg_q && 64'(res_q) > MAXN))) err_d = 1'b1;
        bcd_d = (dd_adjust(bcd_q) << 1) | BW'(res_q[RW-1]);
        res_d = res_q << 1;
        cnt_d = cnt_q + 1'b1;
        // The display takes the result on entry to LOAD so o_done coincides with the new value.
        if (cnt_q == CW'(RW - 1)) begin
          disp_bcd_d = bcd_d;
          disp_neg_d = neg_q;
          disp_err_d = err_q;
          error_d    = err_q;
          state_d    = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      idx_d      = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    sel_nib = disp_bcd_q[4*idx_q +: 4];
    digit_d = '1;
    font_d  = 8'hFF;
    if (i_en) begin
      digit_d = ~(DIGITS'(1) << idx_q);
      if (disp_err_q)
        font_d = (idx_q == '0) ? 8'h86 : 8'hFF;
      else if (disp_neg_q && idx_q == IW'(DIGITS - 1))
        font_d = 8'hBF;
`ifdef LEADING_ZERO_BLANK_EN
      else if (idx_q != '0 && (disp_bcd_q >> {idx_q, 2'b00}) == '0)
        font_d = 8'hFF;
`endif
      else
        font_d = seg7(sel_nib);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      rem_q      <= '0;
      res_q      <= '0;
      neg_q      <= 1'b0;
      err_q      <= 1'b0;
      error_q    <= 1'b0;
      cnt_q      <= '0;
      bcd_q      <= '0;
      disp_bcd_q <= '0;
      disp_neg_q <= 1'b0;
      disp_err_q <= 1'b0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      digit_q    <= '1;
      font_q     <= 8'hFF;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      rem_q      <= rem_d;
      res_q      <= res_d;
      neg_q      <= neg_d;
      err_q      <= err_d;
      error_q    <= error_d;
      cnt_q      <= cnt_d;
      bcd_q      <= bcd_d;
      disp_bcd_q <= disp_bcd_d;
      disp_neg_q <= disp_neg_d;
      disp_err_q <= disp_err_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      digit_q    <= digit_d;
      font_q     <= font_d;
    end
  end

  assign o_busy    = (state_q != IDLE);
  assign o_done    = (state_q == LOAD);
  assign o_error   = error_q;
  assign o_digit   = digit_q;
  assign o_fndFont = font_q;
endmodule
